// File: rtl/wm_extract.sv
// Receive-side difference-expansion watermark extractor: recovers one bit per R pair
// and, when `WM_RESTORE_EN is defined, restores the original R pixels bit-exactly.
module wm_extract #(
    parameter int WM_BITS = 64
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       VSYNC,
    input  logic       IN_VALID,
    input  logic [7:0] DATA_R0,
    input  logic [7:0] DATA_R1,
    input  logic [7:0] DATA_G0,
    input  logic [7:0] DATA_B0,
    input  logic [7:0] DATA_G1,
    input  logic [7:0] DATA_B1,
    output logic       OUT_VALID,
    output logic [7:0] OUT_R0,
    output logic [7:0] OUT_R1,
    output logic [7:0] OUT_G0,
    output logic [7:0] OUT_B0,
    output logic [7:0] OUT_G1,
    output logic [7:0] OUT_B1,
    output logic [7:0] WM_BYTE,
    output logic       WM_BYTE_VALID,
    output logic       EXTRACT_DONE,
    output logic [1:0] dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXTRACT = 2'd1,
        ST_PASS    = 2'd2
    } state_t;

    localparam logic [15:0] LAST_IDX = 16'(WM_BITS - 1);

    state_t      state_q, state_d;
    logic [15:0] pair_cnt_q, pair_cnt_d;
    logic        accept, in_ext, in_last;
    logic [15:0] in_idx;

    // Classification is decided when a pair is accepted and travels with it.
    assign accept  = IN_VALID && (VSYNC || state_q != ST_IDLE);
    assign in_ext  = VSYNC || state_q == ST_EXTRACT;
    assign in_idx  = VSYNC ? 16'd0 : pair_cnt_q;
    assign in_last = in_ext && (in_idx == LAST_IDX);
    assign dbg_state_o = state_q;

    always_comb begin
        state_d    = state_q;
        pair_cnt_d = pair_cnt_q;
        if (VSYNC) begin
            state_d    = (accept && in_last) ? ST_PASS : ST_EXTRACT;
            pair_cnt_d = accept ? 16'd1 : 16'd0;
        end else begin
            if (accept && pair_cnt_q != 16'hFFFF) pair_cnt_d = pair_cnt_q + 16'd1;
            if (state_q == ST_EXTRACT && accept && in_last) state_d = ST_PASS;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= ST_IDLE;
            pair_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            pair_cnt_q <= pair_cnt_d;
        end
    end

    logic       s1_valid_q, s1_ext_q, s1_last_q, s1_bit_q;
    logic [7:0] s1_r0_q, s1_r1_q, s1_g0_q, s1_b0_q, s1_g1_q, s1_b1_q;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            s1_valid_q <= 1'b0;
            s1_ext_q   <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_bit_q   <= 1'b0;
            s1_r0_q    <= 8'd0;
            s1_r1_q    <= 8'd0;
            s1_g0_q    <= 8'd0;
            s1_b0_q    <= 8'd0;
            s1_g1_q    <= 8'd0;
            s1_b1_q    <= 8'd0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_ext_q  <= in_ext;
                s1_last_q <= in_last;
                s1_bit_q  <= DATA_R0[0] ^ DATA_R1[0];
                s1_r0_q   <= DATA_R0;
                s1_r1_q   <= DATA_R1;
                s1_g0_q   <= DATA_G0;
                s1_b0_q   <= DATA_B0;
                s1_g1_q   <= DATA_G1;
                s1_b1_q   <= DATA_B1;
            end
        end
    end

    logic [7:0] out_r0, out_r1;

`ifdef WM_RESTORE_EN
    logic [7:0]        s1_l_q;
    logic signed [8:0] s1_hp_q;
    logic signed [8:0] in_hp;
    logic signed [9:0] h10, l10, r0_w, r1_w;

    assign in_hp = $signed({1'b0, DATA_R0}) - $signed({1'b0, DATA_R1});

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            s1_l_q  <= 8'd0;
            s1_hp_q <= 9'sd0;
        end else if (accept) begin
            s1_l_q  <= 8'(({1'b0, DATA_R0} + {1'b0, DATA_R1}) >> 1);
            s1_hp_q <= in_hp;
        end
    end

    function automatic logic [7:0] clamp8(input logic signed [9:0] v);
        if (v < 10'sd0) return 8'd0;
        else if (v > 10'sd255) return 8'd255;
        else return v[7:0];
    endfunction

    // h = floor(h'/2); both restore terms use floor shifts so the pair inverts exactly.
    assign h10  = $signed({s1_hp_q[8], s1_hp_q}) >>> 1;
    assign l10  = $signed({2'b00, s1_l_q});
    assign r0_w = l10 + ((h10 + 10'sd1) >>> 1);
    assign r1_w = l10 - (h10 >>> 1);

    assign out_r0 = s1_ext_q ? clamp8(r0_w) : s1_r0_q;
    assign out_r1 = s1_ext_q ? clamp8(r1_w) : s1_r1_q;
`else
    assign out_r0 = s1_r0_q;
    assign out_r1 = s1_r1_q;
`endif

    logic [2:0] bit_cnt_q;
    logic [7:0] sh_q, sh_next, byte_out;
    logic       ext_fire, byte_end;

    // A VSYNC edge drops the bit of an old-frame pair still in stage 1.
    assign ext_fire = s1_valid_q && s1_ext_q && !VSYNC;
    assign sh_next  = {sh_q[6:0], s1_bit_q};
    assign byte_end = ext_fire && (bit_cnt_q == 3'd7 || s1_last_q);
    assign byte_out = sh_next << (3'd7 - bit_cnt_q);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            OUT_VALID     <= 1'b0;
            OUT_R0        <= 8'd0;
            OUT_R1        <= 8'd0;
            OUT_G0        <= 8'd0;
            OUT_B0        <= 8'd0;
            OUT_G1        <= 8'd0;
            OUT_B1        <= 8'd0;
            WM_BYTE       <= 8'd0;
            WM_BYTE_VALID <= 1'b0;
            EXTRACT_DONE  <= 1'b0;
            bit_cnt_q     <= 3'd0;
            sh_q          <= 8'd0;
        end else begin
            OUT_VALID <= s1_valid_q;
            if (s1_valid_q) begin
                OUT_R0 <= out_r0;
                OUT_R1 <= out_r1;
                OUT_G0 <= s1_g0_q;
                OUT_B0 <= s1_b0_q;
                OUT_G1 <= s1_g1_q;
                OUT_B1 <= s1_b1_q;
            end
            WM_BYTE_VALID <= byte_end;
            if (byte_end) WM_BYTE <= byte_out;
            if (VSYNC) begin
                bit_cnt_q    <= 3'd0;
                sh_q         <= 8'd0;
                EXTRACT_DONE <= 1'b0;
            end else if (ext_fire) begin
                sh_q      <= sh_next;
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (byte_end && s1_last_q) EXTRACT_DONE <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wm_extract.sv
// Directed bench for wm_extract: two instances (WM_BITS=8 and 12) share one input stream;
// R expectations follow the restore build when WM_RESTORE_EN is defined.
module tb_wm_extract;

    logic       clk, rst, vsync, in_valid;
    logic [7:0] r0, r1, g0, b0, g1, b1;

    logic       o8_valid, o8_bv, o8_done;
    logic [7:0] o8_r0, o8_r1, o8_g0, o8_b0, o8_g1, o8_b1, o8_byte;
    logic [1:0] o8_st;
    logic       o12_valid, o12_bv, o12_done;
    logic [7:0] o12_r0, o12_r1, o12_g0, o12_b0, o12_g1, o12_b1, o12_byte;
    logic [1:0] o12_st;

    wm_extract #(.WM_BITS(8)) dut8 (
        .HCLK(clk), .HRESET(rst), .VSYNC(vsync), .IN_VALID(in_valid),
        .DATA_R0(r0), .DATA_R1(r1), .DATA_G0(g0), .DATA_B0(b0), .DATA_G1(g1), .DATA_B1(b1),
        .OUT_VALID(o8_valid), .OUT_R0(o8_r0), .OUT_R1(o8_r1), .OUT_G0(o8_g0), .OUT_B0(o8_b0),
        .OUT_G1(o8_g1), .OUT_B1(o8_b1), .WM_BYTE(o8_byte), .WM_BYTE_VALID(o8_bv),
        .EXTRACT_DONE(o8_done), .dbg_state_o(o8_st)
    );

    wm_extract #(.WM_BITS(12)) dut12 (
        .HCLK(clk), .HRESET(rst), .VSYNC(vsync), .IN_VALID(in_valid),
        .DATA_R0(r0), .DATA_R1(r1), .DATA_G0(g0), .DATA_B0(b0), .DATA_G1(g1), .DATA_B1(b1),
        .OUT_VALID(o12_valid), .OUT_R0(o12_r0), .OUT_R1(o12_r1), .OUT_G0(o12_g0), .OUT_B0(o12_b0),
        .OUT_G1(o12_g1), .OUT_B1(o12_b1), .WM_BYTE(o12_byte), .WM_BYTE_VALID(o12_bv),
        .EXTRACT_DONE(o12_done), .dbg_state_o(o12_st)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pick(input logic [7:0] raw, input logic [7:0] rest);
`ifdef WM_RESTORE_EN
        return rest;
`else
        return raw;
`endif
    endfunction

    // per-test stimulus and expectation tables
    logic       in_vs   [0:15];
    logic [7:0] in_r0   [0:15];
    logic [7:0] in_r1   [0:15];
    logic [7:0] e8_r0   [0:15];
    logic [7:0] e8_r1   [0:15];
    logic [7:0] e12_r0  [0:15];
    logic [7:0] e12_r1  [0:15];
    logic       e8_stb  [0:15];
    logic       e8_done [0:15];
    logic       e12_stb [0:15];
    logic       e12_done[0:15];
    logic [7:0] exp8_q[$];
    logic [7:0] exp12_q[$];

    task automatic drive_idle();
        vsync = 1'b0; in_valid = 1'b0;
    endtask

    task automatic drive_pair(input logic vs, input logic [7:0] a, input logic [7:0] b, input int i);
        vsync = vs; in_valid = 1'b1; r0 = a; r1 = b;
        g0 = 8'(8'h40 + i); b0 = 8'(8'h80 + i); g1 = 8'(8'hA0 + i); b1 = 8'(8'hC0 + i);
    endtask

    task automatic vsync_pulse();
        @(negedge clk);
        vsync = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        drive_idle();
    endtask

    // Drive n back-to-back pairs; outputs of pair j are checked two negedges after it is driven.
    task automatic run_stream(input int n);
        int j;
        for (int i = 0; i < n + 2; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                j = i - 2;
                check($sformatf("v8[%0d]", j), o8_valid, 1);
                check($sformatf("r0_8[%0d]", j), o8_r0, e8_r0[j]);
                check($sformatf("r1_8[%0d]", j), o8_r1, e8_r1[j]);
                check($sformatf("g0_8[%0d]", j), o8_g0, 8'(8'h40 + j));
                check($sformatf("b1_8[%0d]", j), o8_b1, 8'(8'hC0 + j));
                check($sformatf("r0_12[%0d]", j), o12_r0, e12_r0[j]);
                check($sformatf("r1_12[%0d]", j), o12_r1, e12_r1[j]);
                check($sformatf("stb8[%0d]", j), o8_bv, e8_stb[j]);
                check($sformatf("done8[%0d]", j), o8_done, e8_done[j]);
                check($sformatf("stb12[%0d]", j), o12_bv, e12_stb[j]);
                check($sformatf("done12[%0d]", j), o12_done, e12_done[j]);
                if (e8_stb[j] && exp8_q.size() > 0)
                    check($sformatf("byte8[%0d]", j), o8_byte, exp8_q.pop_front());
                if (e12_stb[j] && exp12_q.size() > 0)
                    check($sformatf("byte12[%0d]", j), o12_byte, exp12_q.pop_front());
            end
            if (i < n) drive_pair(in_vs[i], in_r0[i], in_r1[i], i);
            else drive_idle();
        end
    endtask

    task automatic clear_tables();
        for (int i = 0; i < 16; i++) begin
            in_vs[i] = 1'b0; e8_stb[i] = 1'b0; e8_done[i] = 1'b0;
            e12_stb[i] = 1'b0; e12_done[i] = 1'b0;
        end
    endtask

    // Pair (100+b, 100) carries bit b and restores to (100, 100).
    task automatic bit_pair(input int i, input logic b);
        in_r0[i] = 8'(100 + b); in_r1[i] = 8'd100;
        e8_r0[i] = pick(8'(100 + b), 8'd100); e8_r1[i] = 8'd100;
        e12_r0[i] = e8_r0[i]; e12_r1[i] = 8'd100;
    endtask

    logic [7:0] pat;

    initial begin
        rst = 1'b1; vsync = 1'b0; in_valid = 1'b0;
        r0 = 8'd0; r1 = 8'd0; g0 = 8'd0; b0 = 8'd0; g1 = 8'd0; b1 = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_valid", o8_valid, 0);
        check("rst_r0", o8_r0, 0);
        check("rst_byte", o8_byte, 0);
        check("rst_done", o8_done, 0);
        check("rst_state", o8_st, 0);
        rst = 1'b0;

        // Single pairs: positive and negative difference, both bit 1.
        clear_tables();
        vsync_pulse();
        in_r0[0] = 8'd101; in_r1[0] = 8'd96;
        e8_r0[0] = pick(8'd101, 8'd99); e8_r1[0] = pick(8'd96, 8'd97);
        in_r0[1] = 8'd50;  in_r1[1] = 8'd53;
        e8_r0[1] = pick(8'd50, 8'd50); e8_r1[1] = pick(8'd53, 8'd52);
        for (int i = 0; i < 2; i++) begin e12_r0[i] = e8_r0[i]; e12_r1[i] = e8_r1[i]; end
        run_stream(2);

        // 0xA5 then three extra pairs: WM_BITS=8 passes them, WM_BITS=12 keeps extracting.
        clear_tables();
        pat = 8'hA5;
        for (int i = 0; i < 11; i++) begin
            if (i < 8) bit_pair(i, pat[7-i]);
            else begin
                in_r0[i] = 8'd101; in_r1[i] = 8'd96;
                e8_r0[i] = 8'd101; e8_r1[i] = 8'd96;
                e12_r0[i] = pick(8'd101, 8'd99); e12_r1[i] = pick(8'd96, 8'd97);
            end
            e8_stb[i] = (i == 7); e8_done[i] = (i >= 7); e12_stb[i] = (i == 7);
        end
        exp8_q.push_back(8'hA5);
        exp12_q.push_back(8'hA5);
        vsync_pulse();
        run_stream(11);

        // 12 bits: 0x3C then 1010 -> partial byte 0xA0 with done.
        clear_tables();
        for (int i = 0; i < 12; i++) begin
            pat = (i < 8) ? 8'h3C : 8'hA0;
            bit_pair(i, pat[7 - (i % 8)]);
            if (i >= 8) begin e8_r0[i] = in_r0[i]; e8_r1[i] = in_r1[i]; end
            e8_stb[i] = (i == 7); e8_done[i] = (i >= 7);
            e12_stb[i] = (i == 7 || i == 11); e12_done[i] = (i == 11);
        end
        exp8_q.push_back(8'h3C);
        exp12_q.push_back(8'h3C); exp12_q.push_back(8'hA0);
        vsync_pulse();
        run_stream(12);

        // Five old-frame pairs, then VSYNC coincident with a pair carrying 0x81.
        clear_tables();
        pat = 8'h81;
        for (int i = 0; i < 13; i++) begin
            if (i < 5) begin
                in_r0[i] = 8'd101; in_r1[i] = 8'd100;
                e8_r0[i] = 8'd101; e8_r1[i] = 8'd100;
                e12_r0[i] = 8'd101; e12_r1[i] = 8'd100;
            end else bit_pair(i, pat[7 - (i - 5)]);
            in_vs[i] = (i == 5);
            e8_stb[i] = (i == 12); e12_stb[i] = (i == 12);
            e8_done[i] = (i <= 3) || (i == 12); e12_done[i] = (i <= 3);
        end
        exp8_q.push_back(8'h81);
        exp12_q.push_back(8'h81);
        run_stream(13);

        // Mid-frame reset with pairs in flight.
        @(negedge clk); drive_pair(1'b0, 8'd77, 8'd12, 0);
        @(negedge clk); drive_pair(1'b0, 8'd78, 8'd13, 1);
        @(negedge clk); rst = 1'b1; drive_pair(1'b0, 8'd79, 8'd14, 2);
        @(negedge clk); rst = 1'b0;
        check("hrst_valid8", o8_valid, 0);
        check("hrst_r0_8", o8_r0, 0);
        check("hrst_g0_8", o8_g0, 0);
        check("hrst_byte8", o8_byte, 0);
        check("hrst_stb8", o8_bv, 0);
        check("hrst_done8", o8_done, 0);
        check("hrst_state12", o12_st, 0);
        check("hrst_byte12", o12_byte, 0);
        for (int i = 0; i < 5; i++) begin
            drive_pair(1'b0, 8'd90, 8'd91, i);
            @(negedge clk);
            check($sformatf("idle_v8[%0d]", i), o8_valid, 0);
            check($sformatf("idle_v12[%0d]", i), o12_valid, 0);
        end
        drive_pair(1'b1, 8'd101, 8'd96, 5);
        @(negedge clk); drive_idle();
        @(negedge clk);
        check("resume_v8", o8_valid, 1);
        check("resume_r0", o8_r0, pick(8'd101, 8'd99));
        check("resume_r1", o8_r1, pick(8'd96, 8'd97));
        check("resume_g1", o8_g1, 8'hA5);
        check("resume_state", o8_st, 1);

        check("q8_empty", exp8_q.size(), 0);
        check("q12_empty", exp12_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wm_extract.md
# wm_extract

Reversible watermark extractor and pixel restorer: the receive-side counterpart of the difference-expansion embedder in `image_read`. It consumes the watermarked pixel-pair stream (R channel of each pair carries one bit), recovers the embedded bit stream as bytes, and reconstructs the original R pixels bit-exactly. G/B pass through delay-matched. It sits between the watermarked-image source and `image_write` / a bit-stream sink.

## Interface
- `WM_BITS`, 64: number of embedded bits per frame. These are carried by the first `WM_BITS` pairs of each frame; the rest pass unchanged. Range 1..65535.
- `HCLK` input 1: clock, rising edge.
- `HRESET` input 1: reset. Synchronous, active-high.
- `VSYNC` input 1: frame start, 1-cycle pulse.
- `IN_VALID` input 1: a pair is present on the DATA inputs this cycle.
- `DATA_R0`, `DATA_R1` input 8 each: watermarked R pixels r0', r1'.
- `DATA_G0`, `DATA_B0`, `DATA_G1`, `DATA_B1` input 8 each: pass-through channels.
- `OUT_VALID` output 1: output pair valid.
- `OUT_R0`, `OUT_R1` output 8 each: restored (or passed-through) R pixels.
- `OUT_G0`, `OUT_B0`, `OUT_G1`, `OUT_B1` output 8 each: delayed G/B.
- `WM_BYTE` output 8: extracted watermark byte, MSB = first extracted bit.
- `WM_BYTE_VALID` output 1: 1-cycle strobe for `WM_BYTE`.
- `EXTRACT_DONE` output 1: all `WM_BITS` bits of the current frame have been emitted. Held until the next `VSYNC`.

## Operation
- FSM states and transitions:
  - IDLE → EXTRACT on `VSYNC`.
  - EXTRACT → PASS after pair index `WM_BITS-1` is accepted.
  - `VSYNC` in any state → EXTRACT. This clears the pair counter, bit counter and shift register, and drops `EXTRACT_DONE`.
- IDLE: input pairs are ignored and `OUT_VALID` stays 0.
- Stage 1, on `IN_VALID`:
  - l = (r0' + r1') >> 1, using a 9-bit sum.
  - h' = r0' − r1', 9-bit signed.
- Stage 2:
  - bit b = h'[0].
  - h = h' >>> 1 (arithmetic shift, i.e. floor).
  - r0 = l + ((h+1) >>> 1).
  - r1 = l − (h >>> 1).
  - Computed in 10-bit signed, then clamped to 0..255.
- In EXTRACT, each pair's b is shifted into the byte register MSB-first.
  - On every 8th bit, `WM_BYTE` is loaded and `WM_BYTE_VALID` pulses.
  - If `WM_BITS` mod 8 ≠ 0, the final partial byte is emitted with zeros in the unused LSBs.
- `EXTRACT_DONE` rises in the same cycle as the last byte strobe.
- In PASS, `OUT_R0`/`OUT_R1` equal the input R pixels delayed, with no arithmetic, and no bits are extracted.
- If `VSYNC` and `IN_VALID` are high together, `VSYNC` wins and that pair is pair index 0 of the new frame.

## Timing
- Reset value of all outputs: 0. Both pipeline valid bits are cleared, so in-flight pairs are discarded.
- Latency: 2 cycles from `IN_VALID` to `OUT_VALID`. G/B are delayed identically.
- `WM_BYTE_VALID` is coincident with the `OUT_VALID` of the pair carrying the byte's last bit.
- Full throughput: one pair per cycle, with no backpressure. Gaps in `IN_VALID` are allowed.
- Pair counter is 16 bits and saturates; it does not wrap within a frame.
- A `VSYNC` mid-pipeline does not flush stages 1–2. Those pairs are output with their old-frame classification; only counters are reset.
- `HRESET` mid-frame returns the FSM to IDLE.

## Configuration
- `WM_RESTORE_EN` defined: `OUT_R0`/`OUT_R1` carry the restored pixels during EXTRACT.
- `WM_RESTORE_EN` undefined: the restore datapath is removed. `OUT_R0`/`OUT_R1` always carry the input R pixels delayed 2 cycles. Bit extraction, `WM_BYTE` and `EXTRACT_DONE` are unchanged.

## Test plan
- `VSYNC`, then pair r0'=101, r1'=96 → 2 cycles later `OUT_R0`=99, `OUT_R1`=97, and extracted bit 1.
- Pair r0'=50, r1'=53 (negative diff) → `OUT_R0`=50, `OUT_R1`=52, bit 1.
- `WM_BITS`=8; 8 pairs encoding 0xA5 (bits 1,0,1,0,0,1,0,1), then 3 more pairs → `WM_BYTE`=0xA5 with one strobe on the 8th output and `EXTRACT_DONE`=1. Pairs 9–11 are output unchanged.
- `WM_BITS`=12 with back-to-back pairs → two strobes: full byte, then a byte with the 4 LSBs zero. `EXTRACT_DONE` rises with the second strobe.
- `VSYNC` coincident with `IN_VALID` after 5 pairs of a prior frame → the bit counter restarts, the coincident pair is bit 0 of the new byte, and `EXTRACT_DONE` goes to 0.
- `HRESET` asserted for 1 cycle mid-frame → next cycle all outputs are 0. Pairs are ignored until `VSYNC`.
